// File: rtl/start_req_queue.sv
// start_req_queue: counts pending start requests and drives a level start
// handshake towards a downstream busy counter (accept = o_start && !i_busy),
// with an optional idle gap after each accepted start.
// Optional feature macro: START_REQ_QUEUE_DROP_CNT_EN enables the saturating
// dropped-event counter on o_drop_count; otherwise it is tied to zero.
module start_req_queue #(
   parameter logic [7:0] MAX_PENDING = 8'd15,
   parameter logic [7:0] GAP_CYCLES  = 8'd0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_event,
   input  logic        i_busy,
   output logic        o_start,
   output logic [7:0]  o_pending,
   output logic        o_full,
   output logic        o_overflow,
   output logic [15:0] o_drop_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_GAP
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_pending;
   logic [7:0] w_pending_nxt;
   logic [7:0] r_gap_cnt;
   logic [7:0] w_gap_nxt;
   logic       r_overflow;
   logic       w_accept;
   logic       w_taken;
   logic       w_drop;

   // A full queue still takes an event when an accept frees a slot in the same cycle.
   assign w_accept      = (r_state == S_REQ) && !i_busy;
   assign w_taken       = i_event && ((r_pending < MAX_PENDING) || w_accept);
   assign w_drop        = i_event && !w_taken;
   assign w_pending_nxt = r_pending + {7'd0, w_taken} - {7'd0, w_accept};

   // State, pending count, gap counter and overflow pulse registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= S_IDLE;
         r_pending  <= '0;
         r_gap_cnt  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pending  <= w_pending_nxt;
         r_gap_cnt  <= w_gap_nxt;
         r_overflow <= w_drop;
      end
   end

   // Next-state logic; the gap counter is loaded with GAP_CYCLES-1 so GAP lasts GAP_CYCLES cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_pending_nxt != 8'd0) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (w_accept) begin
               if (GAP_CYCLES != 8'd0) begin
                  w_state_nxt = S_GAP;
                  w_gap_nxt   = GAP_CYCLES - 8'd1;
               end else if (w_pending_nxt == 8'd0) begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (r_gap_cnt != 8'd0) begin
               w_gap_nxt = r_gap_cnt - 8'd1;
            end else begin
               w_state_nxt = (w_pending_nxt != 8'd0) ? S_REQ : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gap_nxt   = '0;
         end
      endcase
   end

   assign o_start    = (r_state == S_REQ);
   assign o_pending  = r_pending;
   assign o_full     = (r_pending == MAX_PENDING);
   assign o_overflow = r_overflow;

`ifdef START_REQ_QUEUE_DROP_CNT_EN
   logic [15:0] r_drop_count;

   // Saturating count of dropped events.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_drop_count <= '0;
      end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
         r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign o_drop_count = r_drop_count;
`else
   assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_start_req_queue.sv
// Testbench for start_req_queue: three instances (MAX=3/GAP=0, MAX=3/GAP=2,
// MAX=1/GAP=0) share clock, reset and stimulus; each scenario checks one.
// Expected output vectors {start, pending, full, overflow} are queued when
// a cycle's stimulus is driven and popped at the next falling edge.
module tb_start_req_queue;

   logic i_clk = 1'b0;
   logic i_reset_n = 1'b0;
   logic i_event = 1'b0;
   logic i_busy = 1'b0;

   logic        a_start, b_start, c_start;
   logic [7:0]  a_pend, b_pend, c_pend;
   logic        a_full, b_full, c_full;
   logic        a_ovf, b_ovf, c_ovf;
   logic [15:0] a_drop, b_drop, c_drop;

   logic [10:0] obs_a, obs_b, obs_c;
   logic [10:0] q_exp[$];
   int          checks = 0;
   int          failures = 0;

   always #5 i_clk = ~i_clk;

   start_req_queue #(.MAX_PENDING(8'd3), .GAP_CYCLES(8'd0)) u_a (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_event(i_event), .i_busy(i_busy),
      .o_start(a_start), .o_pending(a_pend), .o_full(a_full),
      .o_overflow(a_ovf), .o_drop_count(a_drop));

   start_req_queue #(.MAX_PENDING(8'd3), .GAP_CYCLES(8'd2)) u_b (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_event(i_event), .i_busy(i_busy),
      .o_start(b_start), .o_pending(b_pend), .o_full(b_full),
      .o_overflow(b_ovf), .o_drop_count(b_drop));

   start_req_queue #(.MAX_PENDING(8'd1), .GAP_CYCLES(8'd0)) u_c (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_event(i_event), .i_busy(i_busy),
      .o_start(c_start), .o_pending(c_pend), .o_full(c_full),
      .o_overflow(c_ovf), .o_drop_count(c_drop));

   assign obs_a = {a_start, a_pend, a_full, a_ovf};
   assign obs_b = {b_start, b_pend, b_full, b_ovf};
   assign obs_c = {c_start, c_pend, c_full, c_ovf};

   function automatic logic [10:0] mk(input logic s, input int p, input logic f, input logic o);
      logic [7:0] pv;
      pv = p[7:0];
      return {s, pv, f, o};
   endfunction

   task automatic do_reset();
      @(negedge i_clk);
      i_reset_n = 1'b0;
      i_event   = 1'b0;
      i_busy    = 1'b0;
      @(negedge i_clk);
      i_reset_n = 1'b1;
      q_exp.delete();
      q_exp.push_back(11'd0);
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      i_reset_n = 1'b0;
      i_event   = 1'b1;
      i_busy    = 1'b1;
      #1;
      checks++;
      if (obs_a !== 11'd0 || a_drop !== 16'd0) begin
         failures++;
         $display("FAIL reset_state got=%h drop=%h exp=000 drop=0000", obs_a, a_drop);
      end
      // Event present at the release edge must be taken.
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(negedge i_clk);
      i_event = 1'b0;
      checks++;
      if (obs_a !== mk(1'b1, 1, 1'b0, 1'b0)) begin
         failures++;
         $display("FAIL reset_release_event got=%h exp=%h", obs_a, mk(1'b1, 1, 1'b0, 1'b0));
      end
   endtask

   task automatic test_single();
      logic [10:0] e;
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         @(negedge i_clk);
         e = q_exp.pop_front();
         checks++;
         if (obs_a !== e) begin
            failures++;
            $display("FAIL single c%0d got=%h exp=%h", c, obs_a, e);
         end
         i_event = (c == 5);
         i_busy  = 1'b0;
         q_exp.push_back(mk(c + 1 == 6, (c + 1 == 6) ? 1 : 0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_busy_hold();
      logic [10:0] e;
      logic        s;
      do_reset();
      for (int c = 1; c <= 34; c++) begin
         @(negedge i_clk);
         e = q_exp.pop_front();
         checks++;
         if (obs_a !== e) begin
            failures++;
            $display("FAIL busy_hold c%0d got=%h exp=%h", c, obs_a, e);
         end
         i_event = (c == 5);
         i_busy  = (c >= 6 && c <= 30);
         s = (c + 1 >= 6 && c + 1 <= 31);
         q_exp.push_back(mk(s, s ? 1 : 0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_overflow();
      logic [10:0] e;
      int          n, p;
      logic [15:0] exp_drop;
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         @(negedge i_clk);
         e = q_exp.pop_front();
         checks++;
         if (obs_a !== e) begin
            failures++;
            $display("FAIL overflow c%0d got=%h exp=%h", c, obs_a, e);
         end
         i_event = (c >= 1 && c <= 5);
         i_busy  = 1'b1;
         n = c + 1;
         p = (n <= 1) ? 0 : ((n - 1 > 3) ? 3 : n - 1);
         q_exp.push_back(mk(n >= 2, p, n >= 4, (n == 5 || n == 6)));
      end
`ifdef START_REQ_QUEUE_DROP_CNT_EN
      exp_drop = 16'd2;
`else
      exp_drop = 16'd0;
`endif
      checks++;
      if (a_drop !== exp_drop) begin
         failures++;
         $display("FAIL drop_count got=%0d exp=%0d", a_drop, exp_drop);
      end
   endtask

   task automatic test_full_accept();
      logic [10:0] e;
      int          n, p;
      do_reset();
      i_busy = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge i_clk);
         e = q_exp.pop_front();
         checks++;
         if (obs_a !== e) begin
            failures++;
            $display("FAIL full_accept c%0d got=%h exp=%h", c, obs_a, e);
         end
         i_event = (c == 1 || c == 2 || c == 3 || c == 5);
         i_busy  = (c != 5);
         n = c + 1;
         p = (n <= 1) ? 0 : ((n - 1 > 3) ? 3 : n - 1);
         q_exp.push_back(mk(n >= 2, p, n >= 4, 1'b0));
      end
      checks++;
      if (a_drop !== 16'd0) begin
         failures++;
         $display("FAIL full_accept_drop got=%0d exp=0", a_drop);
      end
   endtask

   task automatic test_gap();
      logic [10:0] e;
      int          n, p;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         @(negedge i_clk);
         e = q_exp.pop_front();
         checks++;
         if (obs_b !== e) begin
            failures++;
            $display("FAIL gap c%0d got=%h exp=%h", c, obs_b, e);
         end
         i_event = (c == 1 || c == 2);
         i_busy  = (c <= 2);
         n = c + 1;
         case (n)
            2:       p = 1;
            3:       p = 2;
            4, 5, 6: p = 1;
            default: p = 0;
         endcase
         q_exp.push_back(mk(n == 2 || n == 3 || n == 6, p, 1'b0, 1'b0));
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] e;
      logic        h;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         @(negedge i_clk);
         e = q_exp.pop_front();
         checks++;
         if (obs_c !== e) begin
            failures++;
            $display("FAIL back_to_back c%0d got=%h exp=%h", c, obs_c, e);
         end
         i_event = (c >= 1 && c <= 5);
         i_busy  = 1'b0;
         h = (c + 1 >= 2 && c + 1 <= 6);
         q_exp.push_back(mk(h, h ? 1 : 0, h, 1'b0));
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] e;
      do_reset();
      for (int c = 1; c <= 3; c++) begin
         @(negedge i_clk);
         e = q_exp.pop_front();
         checks++;
         if (obs_a !== e) begin
            failures++;
            $display("FAIL reset_mid_pre c%0d got=%h exp=%h", c, obs_a, e);
         end
         i_event = (c == 1);
         i_busy  = 1'b1;
         q_exp.push_back((c + 1 >= 2) ? mk(1'b1, 1, 1'b0, 1'b0) : 11'd0);
      end
      i_reset_n = 1'b0;
      #1;
      checks++;
      if (obs_a !== 11'd0) begin
         failures++;
         $display("FAIL reset_mid_async got=%h exp=000", obs_a);
      end
      @(negedge i_clk);
      i_reset_n = 1'b1;
      i_busy    = 1'b0;
      i_event   = 1'b0;
      q_exp.delete();
      q_exp.push_back(11'd0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge i_clk);
         e = q_exp.pop_front();
         checks++;
         if (obs_a !== e) begin
            failures++;
            $display("FAIL reset_mid_post c%0d got=%h exp=%h", c, obs_a, e);
         end
         q_exp.push_back(11'd0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_busy_hold();
      test_overflow();
      test_full_accept();
      test_gap();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/start_req_queue.md
START_REQ_QUEUE -- requirements
Module: start_req_queue

Interface
REQ-001 Parameter MAX_PENDING, 8 bits, default 15: pending-request capacity; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, 8 bits, default 0: idle cycles forced between an accepted start and the next o_start.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_event  input  1  single-cycle request pulse; one pulse = one requested start.
REQ-006 i_busy  input  1  busy flag from the downstream busy counter.
REQ-007 o_start  output  1  start request to the downstream busy counter.
REQ-008 o_pending  output  8  requests queued and not yet accepted.
REQ-009 o_full  output  1  high when o_pending == MAX_PENDING.
REQ-010 o_overflow  output  1  one-cycle pulse reporting a dropped event.
REQ-011 o_drop_count  output  16  count of dropped events (see Configuration).

Function
REQ-012 Acceptance SHALL be defined as accept = o_start && !i_busy, sampled at the rising edge of i_clk.
REQ-013 States SHALL be IDLE (o_start=0), REQ (o_start=1) and GAP (o_start=0); o_start SHALL be decoded from the state register only.
REQ-014 Once o_start rises, it SHALL stay high until an accept cycle; no other condition except reset may lower it.
REQ-015 An event SHALL be taken when o_pending < MAX_PENDING, or when o_pending == MAX_PENDING and accept is high in the same cycle; otherwise it SHALL be dropped.
REQ-016 Next o_pending SHALL equal o_pending + taken - accept; event taken plus accept in the same cycle leaves the count unchanged; no wrap, underflow or overflow is possible.
REQ-017 IDLE -> REQ at the edge where the next o_pending is nonzero, so an event into an empty IDLE queue at cycle t gives o_start=1 at t+1.
REQ-018 REQ on accept: if GAP_CYCLES > 0 -> GAP; otherwise stay in REQ if the next o_pending > 0, else -> IDLE.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles, then -> REQ if o_pending > 0, else -> IDLE; events arriving during GAP are still queued.
REQ-020 o_overflow SHALL be a registered pulse, high during the cycle after each dropped event.
REQ-021 With MAX_PENDING = 1 and GAP_CYCLES = 0, back-to-back accepts SHALL be supported: a start held high against a busy counter that stays idle is accepted every cycle while requests remain.

Reset
REQ-022 i_reset_n low SHALL immediately force: state IDLE, o_start=0, o_pending=0, o_full=0, o_overflow=0, gap counter 0, o_drop_count=0.
REQ-023 Reset asserted mid-operation SHALL discard all queued requests; it is the only permitted way o_start falls without an accept.
REQ-024 Reset release SHALL take effect at the first rising edge of i_clk after i_reset_n goes high; an event sampled at that edge is taken.

Configuration
REQ-025 Macro START_REQ_QUEUE_DROP_CNT_EN defined: o_drop_count increments by 1 on each dropped event and saturates at 16'hFFFF.
REQ-026 Macro START_REQ_QUEUE_DROP_CNT_EN undefined: o_drop_count SHALL be tied to 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-027 Bench with MAX_PENDING=3, GAP_CYCLES=0, i_busy=0: single i_event at cycle 5 -> o_start=1 at cycle 6 only, accepted at 6, o_pending back to 0 at cycle 7.
REQ-028 Bench driving i_busy=1 from cycle 6 to cycle 30: event at cycle 5 -> o_start high continuously from cycle 6, accepted at cycle 31, o_start low at 32.
REQ-029 Bench with i_busy=1 held: 5 events -> o_pending=3, o_full=1, two o_overflow pulses; o_drop_count=2 with the macro defined, 0 without it.
REQ-030 Bench at o_pending=3 (full) with an event on the accept cycle -> event taken, o_pending stays 3, no o_overflow pulse.
REQ-031 Bench with GAP_CYCLES=2 and 2 events queued, i_busy=0 -> o_start pattern 1,0,0,1,0, with o_pending going 2,1,1,1,0.
REQ-032 Bench holding o_start high in REQ, then i_reset_n low for 1 cycle -> o_start, o_pending and o_full read 0 during reset, state IDLE after release, no spurious o_start.
